grn_sim_ctrl: RTL and testbench

GRN_SIM_CTRL -- requirements
Module: grn_sim_ctrl

---
 rtl/grn_sim_ctrl.sv | 116 +++++++++++
 tb/tb_grn_sim_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/grn_sim_ctrl.sv
// rtl/grn_sim_ctrl.sv - sweep controller for a boolean-network attractor search
// Steps slow/fast node copies from each initial state until they coincide or time out.
module grn_sim_ctrl #(
    parameter int N_NODES   = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [N_NODES-1:0] init_first,
    input  logic [N_NODES-1:0] init_last,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    output logic               busy,
    output logic               done,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_NODES-1:0] res_init,
    output logic [CNT_W-1:0]   res_steps,
    output logic [N_NODES-1:0] res_state,
    output logic               res_timeout
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, EMIT, DONE} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

    state_t             state;
    state_t             state_nx;
    logic [N_NODES-1:0] cur_init;
    logic [N_NODES-1:0] next_init;
    logic [CNT_W-1:0]   step_cnt;
    logic               match;
    logic               step_en;
    logic               timeout_hit;
    logic               last_init;

    // Only even step counts are compared: the fast copy has then lapped the slow one cleanly.
    assign match       = (state == RUN) && (step_cnt >= CNT_W'(2)) && !step_cnt[0]
                         && (s0_vec == s1_vec);
    assign step_en     = (state == RUN) && !match && (step_cnt != MAX_CNT);
    assign timeout_hit = (state == RUN) && !match && (step_cnt == MAX_CNT);
    assign last_init   = (cur_init == init_last);
    assign next_init   = cur_init + N_NODES'(1);

    assign start_s0 = step_en;
    assign start_s1 = step_en;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = RUN;
            RUN:     if (match || timeout_hit) state_nx = EMIT;
            EMIT:    if (res_ready) state_nx = last_init ? DONE : LOAD;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cur_init    <= '0;
            step_cnt    <= '0;
            init_state  <= '0;
            reset_nos   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            res_valid   <= 1'b0;
            res_init    <= '0;
            res_steps   <= '0;
            res_state   <= '0;
            res_timeout <= 1'b0;
        end else begin
            state     <= state_nx;
            busy      <= (state_nx != IDLE);
            done      <= (state_nx == DONE);
            res_valid <= (state_nx == EMIT);
            reset_nos <= (state_nx == LOAD);
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        cur_init   <= init_first;
                        init_state <= init_first;
                    end
                end
                LOAD: step_cnt <= '0;
                RUN: begin
                    if (step_en) step_cnt <= step_cnt + CNT_W'(1);
                    if (match || timeout_hit) begin
                        res_init    <= cur_init;
                        res_steps   <= step_cnt;
                        res_state   <= s1_vec;
                        res_timeout <= !match;
                    end
                end
                EMIT: begin
                    if (res_ready && !abort && !last_init) begin
                        cur_init   <= next_init;
                        init_state <= next_init;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_grn_sim_ctrl.sv
// tb/tb_grn_sim_ctrl.sv - scoreboard bench for grn_sim_ctrl with a behavioural node array
module tb_grn_sim_ctrl;

    localparam int N  = 8;
    localparam int CW = 16;
    localparam int MS = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [N-1:0]  init_first = '0;
    logic [N-1:0]  init_last = '0;
    logic [N-1:0]  s0_vec;
    logic [N-1:0]  s1_vec;
    logic          reset_nos;
    logic [N-1:0]  init_state;
    logic          start_s0;
    logic          start_s1;
    logic          busy;
    logic          done;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [N-1:0]  res_init;
    logic [CW-1:0] res_steps;
    logic [N-1:0]  res_state;
    logic          res_timeout;

    grn_sim_ctrl #(.N_NODES(N), .CNT_W(CW), .MAX_STEPS(MS)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .init_first(init_first), .init_last(init_last),
        .s0_vec(s0_vec), .s1_vec(s1_vec),
        .reset_nos(reset_nos), .init_state(init_state),
        .start_s0(start_s0), .start_s1(start_s1),
        .busy(busy), .done(done),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_init(res_init), .res_steps(res_steps),
        .res_state(res_state), .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    // 0: identity network, 1: node 0 toggles (period 2), 2: fast copy forced to disagree
    int mode = 0;
    int rdy_mode = 0;
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [N-1:0] f_net(input logic [N-1:0] x);
        return (mode == 1) ? (x ^ 8'h01) : x;
    endfunction

    // Slow copy takes one network step per start pair, fast copy takes two.
    logic [N-1:0] s0_q, s1_q;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q <= '0;
            s1_q <= '0;
        end else if (reset_nos) begin
            s0_q <= init_state;
            s1_q <= init_state;
        end else if (start_s0 && start_s1) begin
            s0_q <= f_net(s0_q);
            s1_q <= f_net(f_net(s1_q));
        end
    end
    assign s0_vec = s0_q;
    assign s1_vec = (mode == 2) ? ~s1_q : s1_q;

    typedef struct {
        logic [N-1:0]  init;
        logic [CW-1:0] steps;
        logic [N-1:0]  state;
        logic          to;
    } exp_t;
    exp_t sb[$];

    function automatic exp_t mk_exp(input logic [N-1:0] i);
        exp_t e;
        e.init = i;
        if (mode == 2) begin
            e.steps = CW'(MS); e.state = ~i; e.to = 1'b1;
        end else begin
            e.steps = 16'd2;   e.state = i;  e.to = 1'b0;
        end
        return e;
    endfunction

    int done_cnt = 0;
    int res_cnt = 0;
    int pulses = 0;
    int overlap = 0;
    int s_diff = 0;
    logic          held = 1'b0;
    logic [N-1:0]  h_init, h_state;
    logic [CW-1:0] h_steps;
    logic          h_to;

    always @(negedge clk) begin
        exp_t e;
        if (done) done_cnt++;
        if (reset_nos) pulses = 0;
        if (start_s0) pulses++;
        if (reset_nos && (start_s0 || start_s1)) overlap++;
        if (start_s0 != start_s1) s_diff++;
        res_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (res_valid) begin
            if (held) begin
                chk("stall_init", 32'(res_init), 32'(h_init));
                chk("stall_steps", 32'(res_steps), 32'(h_steps));
                chk("stall_state", 32'(res_state), 32'(h_state));
                chk("stall_to", 32'(res_timeout), 32'(h_to));
            end
            if (res_ready) begin
                held = 1'b0;
                res_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'(res_init), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("res_init", 32'(res_init), 32'(e.init));
                    chk("res_steps", 32'(res_steps), 32'(e.steps));
                    chk("res_state", 32'(res_state), 32'(e.state));
                    chk("res_timeout", 32'(res_timeout), 32'(e.to));
                    chk("start_pulses", 32'(pulses), 32'(e.steps));
                end
            end else begin
                held = 1'b1;
                h_init = res_init; h_steps = res_steps; h_state = res_state; h_to = res_timeout;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic pulse_start(input logic [N-1:0] f, input logic [N-1:0] l);
        @(negedge clk);
        init_first = f;
        init_last  = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_sweep(input logic [N-1:0] f, input logic [N-1:0] l, input int n);
        int d0, r0;
        logic [N-1:0] v;
        v = f;
        for (int k = 0; k < n; k++) begin
            sb.push_back(mk_exp(v));
            v = v + 8'd1;
        end
        d0 = done_cnt;
        r0 = res_cnt;
        pulse_start(f, l);
        for (int i = 0; i < 2000 && done_cnt == d0; i++) @(negedge clk);
        chk("done_seen", 32'(done_cnt - d0), 32'd1);
        chk("result_count", 32'(res_cnt - r0), 32'(n));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);
        chk("idle_after_done", 32'(busy), 32'd0);
        sb.delete();
    endtask

    initial begin
        int d0, w;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_reset_nos", 32'(reset_nos), 32'd0);
        chk("rst_init_state", 32'(init_state), 32'd0);
        chk("rst_start_s0", 32'(start_s0), 32'd0);
        chk("rst_res_steps", 32'(res_steps), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        mode = 0; rdy_mode = 0; run_sweep(8'h05, 8'h05, 1);
        mode = 1; rdy_mode = 0; run_sweep(8'h3C, 8'h3C, 1);
        mode = 2; rdy_mode = 0; run_sweep(8'hA0, 8'hA0, 1);
        mode = 1; rdy_mode = 1; run_sweep(8'hFE, 8'h01, 4);
        mode = 0; rdy_mode = 1; run_sweep(8'h10, 8'h12, 3);

        // asynchronous reset in the middle of a run
        mode = 2; rdy_mode = 0;
        d0 = done_cnt;
        pulse_start(8'h40, 8'h40);
        for (w = 0; w < 100 && !start_s0; w++) @(negedge clk);
        chk("run_reached", 32'(start_s0), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_valid", 32'(res_valid), 32'd0);
        chk("rst_mid_start", 32'(start_s0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rst_mid_stays_idle", 32'(busy), 32'd0);

        // abort while a result is waiting
        mode = 0; rdy_mode = 2;
        d0 = done_cnt;
        pulse_start(8'h20, 8'h21);
        for (w = 0; w < 100 && !res_valid; w++) @(negedge clk);
        chk("emit_reached", 32'(res_valid), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(res_valid), 32'd0);
        repeat (5) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

        mode = 0; rdy_mode = 0; run_sweep(8'h07, 8'h07, 1);

        chk("no_overlap", 32'(overlap), 32'd0);
        chk("starts_equal", 32'(s_diff), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
